ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single SDRAM byte port (sram controller on clk_sys) between three requesters: the ioctl loader/eraser, the CPU, and a video/DMA fetch engine.
- Selects one requester, issues a single-cycle command strobe, and waits for completion. Returns read data and a one-cycle acknowledge to the winner.
- Sits between the top-level address/data muxing and the sram instance, replacing the ad-hoc ioctl/CPU mux.

Parameters:
AW, 25, byte address width of the memory port
TIMEOUT, 64, clk_sys cycles allowed between command strobe and mem_ready before abort

Ports:
clk_sys     in   1    system clock (96 MHz); all logic on posedge
reset       in   1    synchronous, active-high
ld_req      in   1    loader write request (level, held until ld_ack)
ld_addr     in   AW   loader address
ld_din      in   8    loader write data
ld_ack      out  1    one-cycle completion pulse to loader
cpu_req     in   1    CPU request (level, held until cpu_ack)
cpu_we      in   1    1 = write, 0 = read; sampled with cpu_req
cpu_addr    in   AW   CPU address
cpu_din     in   8    CPU write data
cpu_dout    out  8    registered CPU read data; valid from cpu_ack, held until next CPU read completes
cpu_ack     out  1    one-cycle completion pulse to CPU
vid_req     in   1    video fetch request (read only, level)
vid_addr    in   AW   video address
vid_dout    out  8    registered video read data; valid from vid_ack
vid_ack     out  1    one-cycle completion pulse to video
mem_addr    out  AW   address to sram
mem_din     out  8    write data to sram
mem_we      out  1    write strobe, one cycle
mem_rd      out  1    read strobe, one cycle
mem_dout    in   8    sram read data, valid when mem_ready=1
mem_ready   in   1    sram completion pulse
busy        out  1    high whenever state != IDLE
err         out  1    one-cycle pulse on timeout abort

Behaviour:
- Reset values:
  - all acks, mem_we, mem_rd, err, busy = 0
  - cpu_dout = vid_dout = 8'hFF
  - mem_addr = 0, mem_din = 0
  - state = IDLE; rr pointer = CPU
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: sample requests; at most one grant per arbitration.
  - ld_req has fixed top priority.
  - Otherwise cpu_req vs vid_req is round-robin. The rr pointer favours the requester not granted last; a single requester always wins.
  - On grant: latch the winner's id, addr, din and write flag into mem_addr/mem_din/flag regs; go to ISSUE.
- ISSUE (1 cycle):
  - mem_we = flag or mem_rd = ~flag, exactly one cycle.
  - Loader is always a write; video is always a read.
  - Clear timeout counter; go to WAIT.
- WAIT:
  - On mem_ready: capture mem_dout into a data register if the access is a read; go to DONE.
  - If mem_ready arrives in the same cycle as ISSUE, it is ignored. The controller never completes in under 1 cycle.
  - Timeout counter increments each WAIT cycle. At TIMEOUT-1 without mem_ready: data register = 8'hFF, err pulse, go to DONE.
- DONE (1 cycle):
  - Assert the winner's ack.
  - Update cpu_dout/vid_dout (reads only; CPU writes leave cpu_dout unchanged).
  - Toggle rr pointer if the winner was CPU or video.
  - Go to IDLE.
- Minimum latency: request seen in IDLE at cycle N, strobe at N+1, ack at N+3 when mem_ready comes at N+2.
- A request held after its ack is re-arbitrated as a new request in the following IDLE cycle. Requesters drop req in the cycle after ack to avoid a repeat access.
- Requests arriving while busy wait; their address/data are not sampled until granted.
- mem_addr/mem_din hold their values from grant until the next grant.
- Reset mid-operation: immediate return to IDLE next cycle.
  - Any pending ack is suppressed; strobes are deasserted.
  - The outstanding sram access is abandoned; its late mem_ready in IDLE is ignored.
- Simultaneous ld_req, cpu_req, vid_req: loader first. Then CPU and video alternate per rr pointer.
- Counter width: clog2(TIMEOUT), no wrap before timeout.

Decomposition:
- Package ram_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, DONE}
  - req_id_t enum {REQ_LD, REQ_CPU, REQ_VID}
  - constant DATA_ABORT = 8'hFF
- One sub-module, rr_pick2: combinational two-way round-robin pick with registered pointer input. Loader priority is applied in the parent.

Test Plan:
- CPU read alone: cpu_req, cpu_we=0, addr 0x00C000; mem_ready 1 cycle after the strobe returning 0x3E. Expect mem_rd single cycle with mem_addr=0x00C000; cpu_ack 3 cycles after grant; cpu_dout=0x3E.
- Contention: ld_req (addr 0x100, data 0xA5) and cpu_req same cycle. Expect loader served first (mem_we, mem_din=0xA5, ld_ack), then CPU granted in the next IDLE; cpu_ack after ld_ack.
- Round-robin: cpu_req and vid_req held continuously for 6 accesses. Grants alternate CPU, VID, CPU, VID…; no requester gets two consecutive grants.
- Timeout: CPU read, mem_ready never asserted. err pulses once, cpu_ack follows next cycle, cpu_dout=0xFF, busy drops; total TIMEOUT+2 cycles after the strobe.
- Reset mid-WAIT: reset asserted during WAIT of a video read. Next cycle busy=0, no vid_ack. A late mem_ready is ignored; vid_dout stays 0xFF.
- CPU write: cpu_we=1, data 0x55. Expect mem_we pulse, mem_rd never high, cpu_ack, cpu_dout unchanged from prior read value.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the SDRAM byte-port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        REQ_LD,
        REQ_CPU,
        REQ_VID
    } req_id_t;

    // Read data returned when an access is aborted by the timeout.
    localparam logic [7:0] DATA_ABORT = 8'hFF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. favour_b selects which side wins a tie;
// a lone requester always wins. Pointer storage lives in the parent.
module rr_pick2 (
    input  logic req_a,
    input  logic req_b,
    input  logic favour_b,
    output logic grant_a,
    output logic grant_b
);

    // Tie goes to the favoured side, otherwise the only requester wins.
    always_comb begin
        grant_a = req_a && (!req_b || !favour_b);
        grant_b = req_b && (!req_a ||  favour_b);
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single SDRAM byte port between loader, CPU and video fetch.
// Loader has fixed priority; CPU and video alternate round-robin.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner's command
// ISSUE | one-cycle mem_we / mem_rd strobe, clear timeout counter
// WAIT  | wait for mem_ready or timeout
// DONE  | one-cycle ack to the winner, update round-robin pointer
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW      = 25,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_din,
    output logic          ld_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_dout,
    output logic          vid_ack,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic          busy,
    output logic          err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    state_t          state_nxt;
    req_id_t         owner;
    logic            is_write;
    logic [CW-1:0]   tmo_cnt;
    logic            favour_vid;
    logic            pick_cpu;
    logic            pick_vid;
    logic            timeout_hit;
    logic            access_end;

    rr_pick2 u_pick (
        .req_a    (cpu_req),
        .req_b    (vid_req),
        .favour_b (favour_vid),
        .grant_a  (pick_cpu),
        .grant_b  (pick_vid)
    );

    assign timeout_hit = (state == WAIT) && !mem_ready && (tmo_cnt == CW'(TIMEOUT - 1));
    assign access_end  = (state == WAIT) && (mem_ready || timeout_hit);

    // Next-state decode and the strobe/ack/status outputs derived from state.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        ld_ack    = 1'b0;
        cpu_ack   = 1'b0;
        vid_ack   = 1'b0;
        busy      = (state != IDLE);
        err       = timeout_hit;
        case (state)
            IDLE: begin
                if (ld_req || cpu_req || vid_req) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_we    = is_write;
                mem_rd    = !is_write;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (access_end) state_nxt = DONE;
            end
            DONE: begin
                ld_ack    = (owner == REQ_LD);
                cpu_ack   = (owner == REQ_CPU);
                vid_ack   = (owner == REQ_VID);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, command latch, timeout counter, read data and rr pointer.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= REQ_CPU;
            is_write   <= 1'b0;
            tmo_cnt    <= '0;
            favour_vid <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cpu_dout   <= DATA_ABORT;
            vid_dout   <= DATA_ABORT;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        owner    <= REQ_LD;
                        mem_addr <= ld_addr;
                        mem_din  <= ld_din;
                        is_write <= 1'b1;
                    end else if (pick_cpu) begin
                        owner    <= REQ_CPU;
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_din;
                        is_write <= cpu_we;
                    end else if (pick_vid) begin
                        // Video has no write data; mem_din keeps its last value.
                        owner    <= REQ_VID;
                        mem_addr <= vid_addr;
                        is_write <= 1'b0;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // Read data lands in the output register here so it is
                    // already valid in the ack cycle.
                    if (access_end && !is_write) begin
                        if (owner == REQ_CPU) cpu_dout <= mem_ready ? mem_dout : DATA_ABORT;
                        if (owner == REQ_VID) vid_dout <= mem_ready ? mem_dout : DATA_ABORT;
                    end
                end
                DONE: begin
                    // Favour whichever of CPU/video was not just served.
                    if (owner != REQ_LD) favour_vid <= (owner == REQ_CPU);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a request-level model predicts
// service order, strobes, latency and read data; a monitor checks them.
module tb_ram_port_arbiter;

    localparam int AW      = 25;
    localparam int TIMEOUT = 64;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_din = '0;
    logic          ld_ack;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [7:0]    vid_dout;
    logic          vid_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_rd;
    logic [7:0]    mem_dout = '0;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          err;

    ram_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys   (clk_sys),
        .reset     (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_din    (ld_din),
        .ld_ack    (ld_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_dout  (vid_dout),
        .vid_ack   (vid_ack),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int            who;   // 0 loader, 1 cpu, 2 video
        bit            we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        bit            tmo;
        logic [7:0]    dout;
        int            lat;   // strobe-to-ack cycles
    } exp_t;

    exp_t sq[$];
    exp_t aq[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int err_cnt = 0;

    int         resp_delay = 1;   // 0 = memory never answers
    int         pend = 0;
    logic [7:0] pend_data = '0;
    logic [7:0] sram_mem [logic [AW-1:0]];

    logic [7:0] model_mem [logic [AW-1:0]];
    int         last_cv = 2;      // last of cpu/video served; 2 means CPU is favoured
    logic [7:0] exp_cpu = 8'hFF;
    logic [7:0] exp_vid = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] sram_rd(input logic [AW-1:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk_sys) cyc++;

    // SRAM responder: answers a strobe resp_delay cycles later with one mem_ready.
    always @(negedge clk_sys) begin
        mem_ready = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_ready = 1'b1;
                mem_dout  = pend_data;
            end
        end
        if (mem_we) sram_mem[mem_addr] = mem_din;
        if ((mem_we || mem_rd) && resp_delay > 0) begin
            pend      = resp_delay;
            pend_data = sram_rd(mem_addr);
        end
    end

    // Monitor: pops expectations whenever the DUT strobes memory or acks.
    always @(posedge clk_sys) begin : monitor
        exp_t me;
        int   who;
        #1;
        if (!rst) begin
            if (mem_we || mem_rd) begin
                chk("strobe_expected", 32'(sq.size() != 0), 1);
                if (sq.size() != 0) begin
                    me = sq.pop_front();
                    chk("strobe_we", 32'(mem_we), 32'(me.we));
                    chk("strobe_rd", 32'(mem_rd), 32'(!me.we));
                    chk("strobe_addr", 32'(mem_addr), 32'(me.addr));
                    if (me.we) chk("strobe_din", 32'(mem_din), 32'(me.din));
                end
                strobe_cyc = cyc;
                err_cnt    = 0;
            end
            if (err) err_cnt++;
            if (ld_ack || cpu_ack || vid_ack) begin
                chk("ack_onehot", 32'(int'(ld_ack) + int'(cpu_ack) + int'(vid_ack)), 1);
                chk("ack_expected", 32'(aq.size() != 0), 1);
                if (aq.size() != 0) begin
                    me  = aq.pop_front();
                    who = ld_ack ? 0 : (cpu_ack ? 1 : 2);
                    chk("ack_who", 32'(who), 32'(me.who));
                    chk("ack_latency", 32'(cyc - strobe_cyc), 32'(me.lat));
                    chk("err_count", 32'(err_cnt), 32'(me.tmo));
                    if (who == 1) chk("cpu_dout", 32'(cpu_dout), 32'(me.dout));
                    if (who == 2) chk("vid_dout", 32'(vid_dout), 32'(me.dout));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Model one access in service order and queue its expected strobe and ack.
    task automatic push_access(input int who, input bit we, input logic [AW-1:0] a,
                               input logic [7:0] d, input int dly);
        exp_t       e;
        logic [7:0] rd;
        e.who  = who;
        e.we   = we;
        e.addr = a;
        e.din  = d;
        e.tmo  = (dly == 0);
        e.lat  = e.tmo ? TIMEOUT + 1 : dly + 1;
        rd     = e.tmo ? 8'hFF : model_rd(a);
        if (we) model_mem[a] = d;
        if (who == 1 && !we) exp_cpu = rd;
        if (who == 2) exp_vid = rd;
        e.dout = (who == 2) ? exp_vid : exp_cpu;
        if (who != 0) last_cv = who;
        sq.push_back(e);
        aq.push_back(e);
    endtask

    task automatic model_reset();
        sq.delete();
        aq.delete();
        last_cv = 2;
        exp_cpu = 8'hFF;
        exp_vid = 8'hFF;
    endtask

    task automatic apply_reset();
        ld_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_acks(input int want, input bit drop_all_at_end, output int got);
        int budget;
        got = 0;
        budget = 0;
        while (got < want && budget < 400) begin
            tick();
            budget++;
            if (ld_ack)  begin got++; ld_req = 1'b0; end
            if (cpu_ack) begin got++; if (!drop_all_at_end) cpu_req = 1'b0; end
            if (vid_ack) begin got++; if (!drop_all_at_end) vid_req = 1'b0; end
            if (drop_all_at_end && got >= want) begin cpu_req = 1'b0; vid_req = 1'b0; end
        end
        chk("batch_done", 32'(got), 32'(want));
        if (got != want) apply_reset();
        else begin
            tick();
            chk("idle_after_ack", 32'(busy), 0);
        end
    endtask

    // Raise a set of requests together while the arbiter is idle.
    task automatic run_batch(input bit l, input bit c, input bit v, input bit cwe,
                             input logic [AW-1:0] la, input logic [AW-1:0] ca,
                             input logic [AW-1:0] va, input logic [7:0] ld_d,
                             input logic [7:0] cd, input int dly);
        int order[$];
        int got;
        resp_delay = dly;
        if (l) order.push_back(0);
        if (c && v) begin
            if (last_cv == 1) begin order.push_back(2); order.push_back(1); end
            else              begin order.push_back(1); order.push_back(2); end
        end else if (c) order.push_back(1);
        else if (v) order.push_back(2);
        foreach (order[k]) begin
            case (order[k])
                0:       push_access(0, 1'b1, la, ld_d, dly);
                1:       push_access(1, cwe, ca, cd, dly);
                default: push_access(2, 1'b0, va, 8'h00, dly);
            endcase
        end
        ld_addr = la; ld_din = ld_d;
        cpu_addr = ca; cpu_din = cd; cpu_we = cwe;
        vid_addr = va;
        ld_req = l; cpu_req = c; vid_req = v;
        tick();
        chk("strobe_latency", 32'(mem_we || mem_rd), 1);
        wait_acks(order.size(), 1'b0, got);
    endtask

    // CPU and video both held high for n back-to-back reads.
    task automatic run_rr(input logic [AW-1:0] ca, input logic [AW-1:0] va,
                          input int n, input int dly);
        int who;
        int got;
        resp_delay = dly;
        who = (last_cv == 1) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            push_access(who, 1'b0, (who == 1) ? ca : va, 8'h00, dly);
            who = 3 - who;
        end
        cpu_addr = ca; cpu_we = 1'b0; vid_addr = va;
        cpu_req = 1'b1; vid_req = 1'b1;
        tick();
        chk("strobe_latency", 32'(mem_rd), 1);
        wait_acks(n, 1'b1, got);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acks", 32'(ld_ack || cpu_ack || vid_ack), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h0FF);
        chk("rst_vid_dout", 32'(vid_dout), 32'h0FF);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_din", 32'(mem_din), 0);
        rst = 1'b0;
        tick();

        // CPU read alone, memory answers one cycle after the strobe.
        model_mem[25'h00C000] = 8'h3E;
        sram_mem[25'h00C000]  = 8'h3E;
        run_batch(1'b0, 1'b1, 1'b0, 1'b0, '0, 25'h00C000, '0, 8'h00, 8'h00, 1);
        chk("cpu_read_3e", 32'(cpu_dout), 32'h3E);

        // CPU write leaves the previous read value in cpu_dout.
        run_batch(1'b0, 1'b1, 1'b0, 1'b1, '0, 25'h000200, '0, 8'h00, 8'h55, 2);
        chk("cpu_write_keeps_dout", 32'(cpu_dout), 32'h3E);

        // Loader and CPU together: loader write first, then CPU reads it back.
        run_batch(1'b1, 1'b1, 1'b0, 1'b0, 25'h000100, 25'h000100, '0, 8'hA5, 8'h00, 1);
        chk("contention_readback", 32'(cpu_dout), 32'hA5);

        // CPU and video held continuously: grants alternate.
        run_rr(25'h000044, 25'h000048, 6, 2);

        // CPU read with no memory response: abort after the timeout.
        run_batch(1'b0, 1'b1, 1'b0, 1'b0, '0, 25'h000050, '0, 8'h00, 8'h00, 0);
        chk("timeout_dout", 32'(cpu_dout), 32'h0FF);

        // Reset while a video read is waiting; the late mem_ready must be ignored.
        resp_delay = 6;
        push_access(2, 1'b0, 25'h000300, 8'h00, 6);
        vid_addr = 25'h000300;
        vid_req  = 1'b1;
        tick();
        chk("rst_test_strobe", 32'(mem_rd), 1);
        tick();
        tick();
        rst = 1'b1;
        vid_req = 1'b0;
        model_reset();
        tick();
        chk("midwait_busy", 32'(busy), 0);
        chk("midwait_no_ack", 32'(vid_ack), 0);
        rst = 1'b0;
        repeat (8) tick();
        chk("midwait_vid_dout", 32'(vid_dout), 32'h0FF);
        chk("midwait_idle", 32'(busy), 0);

        // Randomised mixes of simultaneous requests.
        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(1, 7));
            run_batch(sel[0], sel[1], sel[2], 1'($urandom_range(0, 1)),
                      AW'(32'h40 + $urandom_range(0, 15)),
                      AW'(32'h40 + $urandom_range(0, 15)),
                      AW'(32'h40 + $urandom_range(0, 15)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      int'($urandom_range(1, 4)));
        end

        chk("queues_drained", 32'(sq.size() + aq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
